// File: rtl/multi_clkdiv_blinker.sv
// Prescaled divider bank: each LED channel divides a shared base tick by a
// half-unit ratio taken from a rotating mode table, and toggles its output.
module multi_clkdiv_blinker #(
  parameter int NUM_CH      = 2,
  parameter int NUM_MODES   = 4,
  parameter logic [8*NUM_MODES-1:0] MODE_TABLE = 32'h0A080704,
  parameter int PRESCALE    = 1048576,
  parameter int DWELL_TICKS = 64,
  localparam int MW = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              key_i,
  output logic [NUM_CH-1:0] led,
  output logic [MW-1:0]     mode_idx,
  output logic              tick,
  output logic              mode_chg
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  logic [PW-1:0]     presc;
  logic [DW-1:0]     dwell;
  logic [7:0]        acc      [NUM_CH];
  logic [7:0]        acc_next [NUM_CH];
  logic [7:0]        ratio    [NUM_CH];
  logic [NUM_CH-1:0] toggle;
  logic              base_tick;
  logic              dwell_last;
  logic [8:0]        sum;
  logic [8:0]        diff;
  logic [7:0]        entry;
  int                idx;

  assign base_tick  = (presc == PW'(PRESCALE - 1));
  assign dwell_last = (dwell == DW'(DWELL_TICKS - 1));

  // Ratio lookup and accumulator step; the 9-bit sum keeps acc+2 from wrapping.
  always_comb begin
    idx   = 0;
    entry = '0;
    sum   = '0;
    diff  = '0;
    toggle = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      idx      = (int'(mode_idx) + c) % NUM_MODES;
      entry    = MODE_TABLE[8*idx +: 8];
      ratio[c] = (entry < 8'd2) ? 8'd2 : entry;
      sum      = {1'b0, acc[c]} + 9'd2;
      diff     = sum - {1'b0, ratio[c]};
      if (sum >= {1'b0, ratio[c]}) begin
        toggle[c]   = 1'b1;
        acc_next[c] = diff[7:0];
      end else begin
        acc_next[c] = sum[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      presc    <= '0;
      dwell    <= '0;
      led      <= '0;
      mode_idx <= '0;
      tick     <= 1'b0;
      mode_chg <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else if (key_i) begin
      tick     <= 1'b0;
      mode_chg <= 1'b0;
    end else begin
      tick     <= base_tick;
      mode_chg <= base_tick && dwell_last;
      presc    <= base_tick ? '0 : presc + 1'b1;
      if (base_tick) begin
        led <= led ^ toggle;
        // A mode advance restarts every accumulator, after the toggle decision.
        if (dwell_last) begin
          dwell    <= '0;
          mode_idx <= (mode_idx == MW'(NUM_MODES - 1)) ? '0 : mode_idx + 1'b1;
          for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
        end else begin
          dwell <= dwell + 1'b1;
          for (int c = 0; c < NUM_CH; c++) acc[c] <= acc_next[c];
        end
      end
    end
  end

endmodule
